cp0_timer: RTL and testbench

CP0_TIMER -- requirements
Module: cp0_timer

---
 rtl/cp0_timer.sv | 118 +++++++++++
 tb/tb_cp0_timer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cp0_timer.sv
// cp0_timer -- CP0 Count/Compare timer with a prescaler and N_CMP compare channels.
//
// Ports:
//   clk          sole clock, rising edge
//   rst          asynchronous active-low reset
//   we_i         CP0 write enable
//   waddr_i      CP0 write register number (Count = 9/0, Compare k = 11/k)
//   wsel_i       CP0 write select
//   data_i       CP0 write data (low COUNT_W bits used)
//   raddr_i      CP0 read register number
//   rsel_i       CP0 read select
//   count_en_i   run enable; low freezes Count and the prescaler
//   data_o       combinational read data, zero-extended; 0 for unmapped pairs
//   count_o      current Count
//   timer_int_o  per-channel sticky interrupt pending
//   timer_irq_o  OR of timer_int_o (Cause.IP7)
module cp0_timer #(
    parameter int unsigned COUNT_W = 32,
    parameter int unsigned N_CMP   = 2,
    parameter int unsigned DIV     = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               we_i,
    input  logic [4:0]         waddr_i,
    input  logic [2:0]         wsel_i,
    input  logic [31:0]        data_i,
    input  logic [4:0]         raddr_i,
    input  logic [2:0]         rsel_i,
    input  logic               count_en_i,
    output logic [31:0]        data_o,
    output logic [COUNT_W-1:0] count_o,
    output logic [N_CMP-1:0]   timer_int_o,
    output logic               timer_irq_o
);

    localparam int unsigned      PRE_W    = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);

    logic [PRE_W-1:0]   pre_q;
    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] cmp_q [N_CMP];
    logic [N_CMP-1:0]   valid_q;
    logic [N_CMP-1:0]   int_q;

    logic               count_wr;
    logic [N_CMP-1:0]   cmp_wr;
    logic               tick;

    // With DIV=1 the prescaler is pinned at 0 == PRE_LAST, so every enabled cycle ticks.
    assign tick     = count_en_i && (pre_q == PRE_LAST);
    assign count_wr = we_i && (waddr_i == 5'd9) && (wsel_i == 3'd0);

    always_comb begin
        cmp_wr = '0;
        for (int unsigned k = 0; k < N_CMP; k++) begin
            cmp_wr[k] = we_i && (waddr_i == 5'd11) && (wsel_i == 3'(k));
        end
    end

    // Count and prescaler; a Count write overrides a coincident tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q   <= '0;
            count_q <= '0;
        end else if (count_wr) begin
            pre_q   <= '0;
            count_q <= data_i[COUNT_W-1:0];
        end else if (count_en_i) begin
            if (tick) begin
                pre_q   <= '0;
                count_q <= count_q + COUNT_W'(1);
            end else begin
                pre_q   <= pre_q + PRE_W'(1);
            end
        end
    end

    // Compare channels. Matching looks only at the registered Count, so a
    // frozen Count that equals Compare keeps re-arming the pending bit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < N_CMP; k++) begin
                cmp_q[k] <= '0;
            end
            valid_q <= '0;
            int_q   <= '0;
        end else begin
            for (int unsigned k = 0; k < N_CMP; k++) begin
                if (cmp_wr[k]) begin
                    cmp_q[k]   <= data_i[COUNT_W-1:0];
                    valid_q[k] <= 1'b1;
                    int_q[k]   <= 1'b0;
                end else if (valid_q[k] && (count_q == cmp_q[k])) begin
                    int_q[k]   <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        data_o = '0;
        if ((raddr_i == 5'd9) && (rsel_i == 3'd0)) begin
            data_o = 32'(count_q);
        end else if (raddr_i == 5'd11) begin
            for (int unsigned k = 0; k < N_CMP; k++) begin
                if (rsel_i == 3'(k)) begin
                    data_o = 32'(cmp_q[k]);
                end
            end
        end
    end

    assign count_o     = count_q;
    assign timer_int_o = int_q;
    assign timer_irq_o = |int_q;

endmodule

// File: tb/tb_cp0_timer.sv
// tb_cp0_timer -- scoreboard bench for cp0_timer.
// Instance u_a: COUNT_W=32, N_CMP=2, DIV=2. Instance u_b: COUNT_W=16, N_CMP=2, DIV=1.
// Stimulus drives 1 time unit after each rising edge and queues expected values
// tagged with the cycle they apply to; the monitor checks them on the falling edge.
module tb_cp0_timer;

    localparam int K_A_CNT = 0;
    localparam int K_A_INT = 1;
    localparam int K_A_IRQ = 2;
    localparam int K_A_RD  = 3;
    localparam int K_B_CNT = 4;
    localparam int K_B_INT = 5;
    localparam int K_B_IRQ = 6;
    localparam int K_B_RD  = 7;

    logic        clk;
    logic        rst;
    logic        a_we, b_we;
    logic [4:0]  a_waddr, b_waddr;
    logic [2:0]  a_wsel, b_wsel;
    logic [31:0] a_wdata, b_wdata;
    logic [4:0]  raddr;
    logic [2:0]  rsel;
    logic        a_en, b_en;

    logic [31:0] a_rd, b_rd;
    logic [31:0] a_count;
    logic [15:0] b_count;
    logic [1:0]  a_int, b_int;
    logic        a_irq, b_irq;

    typedef struct {
        int unsigned cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } chk_t;

    chk_t        sb[$];
    int unsigned cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    cp0_timer #(.COUNT_W(32), .N_CMP(2), .DIV(2)) u_a (
        .clk(clk), .rst(rst), .we_i(a_we), .waddr_i(a_waddr), .wsel_i(a_wsel),
        .data_i(a_wdata), .raddr_i(raddr), .rsel_i(rsel), .count_en_i(a_en),
        .data_o(a_rd), .count_o(a_count), .timer_int_o(a_int), .timer_irq_o(a_irq)
    );

    cp0_timer #(.COUNT_W(16), .N_CMP(2), .DIV(1)) u_b (
        .clk(clk), .rst(rst), .we_i(b_we), .waddr_i(b_waddr), .wsel_i(b_wsel),
        .data_i(b_wdata), .raddr_i(raddr), .rsel_i(rsel), .count_en_i(b_en),
        .data_o(b_rd), .count_o(b_count), .timer_int_o(b_int), .timer_irq_o(b_irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(input int kind);
        case (kind)
            K_A_CNT: return a_count;
            K_A_INT: return 32'(a_int);
            K_A_IRQ: return 32'(a_irq);
            K_A_RD:  return a_rd;
            K_B_CNT: return 32'(b_count);
            K_B_INT: return 32'(b_int);
            K_B_IRQ: return 32'(b_irq);
            default: return b_rd;
        endcase
    endfunction

    // Monitor: compare every queued expectation that falls due this cycle.
    always @(negedge clk) begin
        int unsigned i;
        logic [31:0] obs;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].cyc == cyc) begin
                obs = observe(sb[i].kind);
                n_checks++;
                if (obs !== sb[i].exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h (cycle %0d)", sb[i].name, obs, sb[i].exp, cyc);
                end
                sb.delete(i);
            end else if (sb[i].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL %s: not sampled, expected %h at cycle %0d", sb[i].name, sb[i].exp, sb[i].cyc);
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    function automatic void push_exp(input int kind, input string name,
                                     input int unsigned delay, input logic [31:0] v);
        chk_t c;
        c.cyc  = cyc + delay;
        c.kind = kind;
        c.exp  = v;
        c.name = name;
        sb.push_back(c);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle CP0 write to instance A (b=0) or B (b=1); consumes one clock.
    task automatic wr(input bit b, input logic [4:0] a, input logic [2:0] s, input logic [31:0] d);
        if (b) begin
            b_we = 1'b1; b_waddr = a; b_wsel = s; b_wdata = d;
        end else begin
            a_we = 1'b1; a_waddr = a; a_wsel = s; a_wdata = d;
        end
        step();
        a_we = 1'b0;
        b_we = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        a_we = 1'b0; a_waddr = '0; a_wsel = '0; a_wdata = '0;
        b_we = 1'b0; b_waddr = '0; b_wsel = '0; b_wdata = '0;
        raddr = 5'd9; rsel = 3'd0;
        a_en = 1'b0; b_en = 1'b0;

        repeat (2) step();
        push_exp(K_A_CNT, "rst_cnt_a", 0, 32'h0);
        push_exp(K_A_INT, "rst_int_a", 0, 32'h0);
        push_exp(K_A_IRQ, "rst_irq_a", 0, 32'h0);
        push_exp(K_B_CNT, "rst_cnt_b", 0, 32'h0);
        push_exp(K_A_RD,  "rst_rd_cnt", 0, 32'h0);
        rst = 1'b1;
        step();

        // First tick after reset lands DIV enabled cycles later; no match while Compare invalid.
        a_en = 1'b1;
        push_exp(K_A_CNT, "first_tick_wait", 1, 32'h0);
        push_exp(K_A_CNT, "first_tick", 2, 32'h1);
        push_exp(K_A_INT, "no_match_after_rst", 2, 32'h0);
        step();
        step();

        // Count write with prescaler at 0, read of same register returns the old value.
        push_exp(K_A_RD,  "rd_old_on_write", 0, 32'h1);
        push_exp(K_A_CNT, "cnt_load0", 1, 32'h0);
        push_exp(K_A_CNT, "div2_9cyc", 10, 32'h4);
        push_exp(K_A_CNT, "div2_10cyc", 11, 32'h5);
        wr(1'b0, 5'd9, 3'd0, 32'h0);
        repeat (10) step();
        step();

        // Freeze with prescaler mid-way for 7 cycles; it must resume from where it stopped.
        a_en = 1'b0;
        for (int k = 1; k <= 7; k++) push_exp(K_A_CNT, "frozen", k, 32'h5);
        repeat (7) step();
        a_en = 1'b1;
        push_exp(K_A_CNT, "resume_pre_held", 1, 32'h6);
        step();
        step();

        // Count write coincident with a tick wins and clears the prescaler.
        push_exp(K_A_CNT, "wr_beats_tick", 1, 32'h100);
        push_exp(K_A_CNT, "pre_cleared", 2, 32'h100);
        push_exp(K_A_CNT, "tick_after_load", 3, 32'h101);
        wr(1'b0, 5'd9, 3'd0, 32'h100);
        step();
        step();

        a_en = 1'b0;
        push_exp(K_A_CNT, "load_while_frozen", 1, 32'h55);
        push_exp(K_A_CNT, "hold_after_load", 3, 32'h55);
        wr(1'b0, 5'd9, 3'd0, 32'h55);
        step();
        step();

        // Instance B: 16-bit wrap with DIV=1, upper data bits discarded.
        b_en = 1'b1;
        raddr = 5'd9; rsel = 3'd0;
        push_exp(K_B_CNT, "wrap_load", 1, 32'hFFFF);
        push_exp(K_B_RD,  "rd_zero_ext", 1, 32'h0000FFFF);
        push_exp(K_B_CNT, "wrap_zero", 2, 32'h0);
        push_exp(K_B_INT, "wrap_no_int", 2, 32'h0);
        push_exp(K_B_INT, "wrap_no_int2", 3, 32'h0);
        wr(1'b1, 5'd9, 3'd0, 32'hABCD_FFFF);
        step();
        step();

        // Compare1 = 0x10, Count = 0x0E.
        raddr = 5'd11; rsel = 3'd1;
        push_exp(K_B_RD, "rd_cmp1", 1, 32'h10);
        wr(1'b1, 5'd11, 3'd1, 32'h10);
        push_exp(K_B_CNT, "cnt_0e", 1, 32'h0E);
        push_exp(K_B_CNT, "cnt_10", 3, 32'h10);
        push_exp(K_B_INT, "no_int_at_eq", 3, 32'h0);
        push_exp(K_B_INT, "int1_set", 4, 32'h2);
        push_exp(K_B_INT, "int1_2cyc", 5, 32'h2);
        push_exp(K_B_IRQ, "irq_set", 5, 32'h1);
        wr(1'b1, 5'd9, 3'd0, 32'h0E);
        repeat (5) step();

        // Compare write on a frozen matching Count clears, then match re-sets.
        b_en = 1'b0;
        push_exp(K_B_CNT, "frozen_10", 1, 32'h10);
        wr(1'b1, 5'd9, 3'd0, 32'h10);
        push_exp(K_B_INT, "pending_before_cmpwr", 0, 32'h2);
        push_exp(K_B_INT, "cmp_wr_wins", 1, 32'h0);
        push_exp(K_B_INT, "reset_on_frozen_match", 2, 32'h2);
        wr(1'b1, 5'd11, 3'd1, 32'h10);
        step();

        // Unmapped writes are ignored.
        push_exp(K_B_INT, "ign_11_2", 1, 32'h2);
        push_exp(K_B_INT, "ign_11_2b", 2, 32'h2);
        wr(1'b1, 5'd11, 3'd2, 32'h10);
        step();
        push_exp(K_B_CNT, "ign_10_0", 1, 32'h10);
        push_exp(K_B_CNT, "ign_9_1", 2, 32'h10);
        wr(1'b1, 5'd10, 3'd0, 32'h20);
        wr(1'b1, 5'd9, 3'd1, 32'h20);

        // Unmapped reads return 0.
        raddr = 5'd11; rsel = 3'd3;
        push_exp(K_B_RD, "rd_11_3", 0, 32'h0);
        step();
        raddr = 5'd9; rsel = 3'd1;
        push_exp(K_B_RD, "rd_9_1", 0, 32'h0);
        step();
        raddr = 5'd12; rsel = 3'd0;
        push_exp(K_B_RD, "rd_12_0", 0, 32'h0);
        step();

        // Compare0 = 0 is a normal matching value.
        b_en = 1'b1;
        wr(1'b1, 5'd11, 3'd0, 32'h0);
        push_exp(K_B_INT, "cmp0_not_yet", 3, 32'h2);
        push_exp(K_B_INT, "cmp0_match", 4, 32'h3);
        wr(1'b1, 5'd9, 3'd0, 32'hFFFE);
        repeat (4) step();

        // Asynchronous reset between edges with an interrupt pending.
        raddr = 5'd11; rsel = 3'd1;
        push_exp(K_B_IRQ, "irq_pre_rst", 0, 32'h1);
        step();
        rst = 1'b0;
        push_exp(K_B_CNT, "async_rst_cnt", 0, 32'h0);
        push_exp(K_B_INT, "async_rst_int", 0, 32'h0);
        push_exp(K_B_IRQ, "async_rst_irq", 0, 32'h0);
        push_exp(K_B_RD,  "async_rst_cmp1", 0, 32'h0);
        push_exp(K_A_CNT, "async_rst_cnt_a", 0, 32'h0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        step();
        raddr = 5'd11; rsel = 3'd0;
        push_exp(K_B_RD,  "rd_cmp0_after_rst", 0, 32'h0);
        push_exp(K_B_CNT, "cnt_after_rst", 0, 32'h1);
        push_exp(K_B_INT, "no_match_after_rst_b", 0, 32'h0);
        push_exp(K_B_INT, "no_match_after_rst_b2", 2, 32'h0);
        repeat (3) step();

        for (int t = 0; t < 20 && sb.size() > 0; t++) step();
        while (sb.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: never sampled, expected %h", sb[0].name, sb[0].exp);
            sb.delete(0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
